// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR PMP scrubber: FSM states, entry classification
// and the three-way compare/majority helper.
package cv32e40p_pkg;

    localparam int TMR_MAX_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } scrub_state_e;

    typedef enum logic [1:0] {
        FT_CLEAN  = 2'd0,
        FT_SINGLE = 2'd1,
        FT_UNCORR = 2'd2
    } fault_t;

    typedef struct packed {
        fault_t                 ft;
        logic [2:0]             faulty;
        logic [TMR_MAX_W-1:0]   majority;
    } tmr_class_t;

    // Classify one entry across the three replicas; faulty is one-hot with bit0=replica 1.
    function automatic tmr_class_t tmr_classify(input logic [TMR_MAX_W-1:0] a,
                                                input logic [TMR_MAX_W-1:0] b,
                                                input logic [TMR_MAX_W-1:0] c);
        tmr_class_t r;
        r.ft       = FT_CLEAN;
        r.faulty   = 3'b000;
        r.majority = a;
        if (a == b && b == c) begin
            r.ft = FT_CLEAN;
        end else if (a == b) begin
            r.ft       = FT_SINGLE;
            r.faulty   = 3'b100;
            r.majority = a;
        end else if (a == c) begin
            r.ft       = FT_SINGLE;
            r.faulty   = 3'b010;
            r.majority = a;
        end else if (b == c) begin
            r.ft       = FT_SINGLE;
            r.faulty   = 3'b001;
            r.majority = b;
        end else begin
            r.ft       = FT_UNCORR;
            r.majority = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_entry_cmp.sv
// Combinational compare/majority of one entry across three replicas.
module cv32e40p_tmr_entry_cmp
    import cv32e40p_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output fault_t           ft,
    output logic [2:0]       faulty,
    output logic [WIDTH-1:0] majority
);

    tmr_class_t cls;

    assign cls      = tmr_classify(TMR_MAX_W'(a), TMR_MAX_W'(b), TMR_MAX_W'(c));
    assign ft       = cls.ft;
    assign faulty   = cls.faulty;
    assign majority = cls.majority[WIDTH-1:0];

    // Upper bits of the widened majority are always zero here.
    if (WIDTH < TMR_MAX_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^cls.majority[TMR_MAX_W-1:WIDTH];
    end

endmodule

// File: rtl/cv32e40p_tmr_scrubber_2d.sv
// Sequential scrubber for the triplicated PMP config/address arrays.
// Optional corrected-error counter: define CV32E40P_SCRUB_ERR_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start_i
// SCAN   | comparing entry idx across the three replicas
// CORR   | holding correction request until corr_gnt_i
// DONE   | last entry finished, pulse done_o
module cv32e40p_tmr_scrubber_2d
    import cv32e40p_pkg::*;
#(
    parameter int N_PMP_ENTRIES = 16,
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 8,
    localparam int IDX_W        = $clog2(N_PMP_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] res1_i [N_PMP_ENTRIES],
    input  logic [WIDTH-1:0] res2_i [N_PMP_ENTRIES],
    input  logic [WIDTH-1:0] res3_i [N_PMP_ENTRIES],
    output logic             busy_o,
    output logic             done_o,
    output logic             corr_req_o,
    input  logic             corr_gnt_i,
    output logic [IDX_W-1:0] corr_idx_o,
    output logic [WIDTH-1:0] corr_data_o,
    output logic [2:0]       corr_we_o,
    output logic             fault_o,
    output logic             uncorr_o,
    output logic [IDX_W-1:0] uncorr_idx_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PMP_ENTRIES - 1);

    scrub_state_e     state;
    logic [IDX_W-1:0] idx;
    fault_t           ft;
    logic [2:0]       faulty;
    logic [WIDTH-1:0] majority;
    logic             fault_set;
    logic             uncorr_set;

    cv32e40p_tmr_entry_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a        (res1_i[idx]),
        .b        (res2_i[idx]),
        .c        (res3_i[idx]),
        .ft       (ft),
        .faulty   (faulty),
        .majority (majority)
    );

    assign fault_set  = (state == S_CORR) && corr_gnt_i && !abort_i;
    assign uncorr_set = (state == S_SCAN) && (ft == FT_UNCORR) && !abort_i;

    // Scan FSM, index counter and correction handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            corr_req_o  <= 1'b0;
            corr_idx_o  <= '0;
            corr_data_o <= '0;
            corr_we_o   <= 3'b000;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state      <= S_IDLE;
                idx        <= '0;
                busy_o     <= 1'b0;
                corr_req_o <= 1'b0;
                corr_we_o  <= 3'b000;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            state  <= S_SCAN;
                            idx    <= '0;
                            busy_o <= 1'b1;
                        end
                    end
                    S_SCAN: begin
                        if (ft == FT_SINGLE) begin
                            state       <= S_CORR;
                            corr_req_o  <= 1'b1;
                            corr_idx_o  <= idx;
                            corr_data_o <= majority;
                            corr_we_o   <= faulty;
                        end else if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_CORR: begin
                        if (corr_gnt_i) begin
                            corr_req_o <= 1'b0;
                            corr_we_o  <= 3'b000;
                            if (idx == LAST_IDX) begin
                                state <= S_DONE;
                            end else begin
                                state <= S_SCAN;
                                idx   <= idx + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        idx    <= '0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky fault status; a same-cycle set wins over clr_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_o      <= 1'b0;
            uncorr_o     <= 1'b0;
            uncorr_idx_o <= '0;
        end else begin
            if (fault_set) begin
                fault_o <= 1'b1;
            end else if (clr_i) begin
                fault_o <= 1'b0;
            end
            if (uncorr_set) begin
                uncorr_o <= 1'b1;
                if (!uncorr_o || clr_i) begin
                    uncorr_idx_o <= idx;
                end
            end else if (clr_i) begin
                uncorr_o     <= 1'b0;
                uncorr_idx_o <= '0;
            end
        end
    end

`ifdef CV32E40P_SCRUB_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Saturating count of completed corrections.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (fault_set) begin
            if (clr_i) begin
                err_cnt_q <= CNT_W'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule
